// File: rtl/alu_pkg.sv
// Shared shift-unit definitions: datapath width, op encoding and the stage A record.
package alu_pkg;

  localparam int XLEN = 64;
  localparam int SHW  = $clog2(XLEN);

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLLW = 3'b100,
    OP_SRLW = 3'b101,
    OP_SRAW = 3'b110
  } shift_op_e;

  // Decoded request: operand is pre-reversed for left shifts, neg marks an
  // arithmetic shift of a negative value.
  typedef struct packed {
    logic [XLEN-1:0] opnd;
    logic [SHW-1:0]  shamt;
    logic            left;
    logic            word;
    logic            neg;
    logic            err;
  } stage_a_t;

endpackage

// File: rtl/shift_pipe_srl.sv
// Logarithmic logical right shifter shared by every shift flavour.
module srl #(
  parameter int N = 64
) (
  input  logic [N-1:0]         din,
  input  logic [$clog2(N)-1:0] shamt,
  output logic [N-1:0]         dout
);

  localparam int LVL = $clog2(N);

  logic [N-1:0] stage [LVL+1];

  always_comb begin
    stage[0] = din;
    for (int i = 0; i < LVL; i++) begin
      stage[i+1] = shamt[i] ? (stage[i] >> (1 << i)) : stage[i];
    end
    dout = stage[LVL];
  end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage 64-bit shift unit: decode into stage A, shared right shifter,
// result fix-up (reverse, sign mask, word extension) into stage B.
module shift_pipe
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            out_err
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Ready never depends on valid; a stage advances when it is empty or its
  // downstream stage advances, so a full stalled pipe holds its contents.
  logic     a_valid, b_valid;
  logic     a_adv, b_adv;
  stage_a_t a_q, a_d;

  logic [XLEN-1:0] srl_out, shifted, sign_mask, fin;
  logic            unused_rs2;

  assign b_adv    = !b_valid || out_ready;
  assign a_adv    = !a_valid || b_adv;
  assign in_ready = a_adv;
  assign out_valid = b_valid;

  assign unused_rs2 = ^rs2[XLEN-1:6];

  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
    return r;
  endfunction

  always_comb begin
    logic [XLEN-1:0] base;
    logic            sign;
    logic            arith;
    a_d   = '0;
    arith = 1'b0;
    case (shift_op_e'(op))
      OP_SLL:  a_d.left = 1'b1;
      OP_SRL:  ;
      OP_SRA:  arith = 1'b1;
      OP_SLLW: begin a_d.left = 1'b1; a_d.word = 1'b1; end
      OP_SRLW: a_d.word = 1'b1;
      OP_SRAW: begin arith = 1'b1; a_d.word = 1'b1; end
      default: a_d.err = 1'b1;
    endcase
    base      = a_d.word ? {32'b0, rs1[31:0]} : rs1;
    sign      = a_d.word ? rs1[31] : rs1[XLEN-1];
    a_d.opnd  = a_d.left ? bit_rev(base) : base;
    a_d.shamt = a_d.word ? {1'b0, rs2[4:0]} : rs2[5:0];
    a_d.neg   = arith && sign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
    end else if (flush) begin
      a_valid <= 1'b0;
    end else if (a_adv) begin
      a_valid <= in_valid;
    end
  end

  // Stage A payload is only meaningful alongside a_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (a_adv && in_valid) a_q <= a_d;
  end

  srl #(.N(XLEN)) u_srl (
    .din   (a_q.opnd),
    .shamt (a_q.shamt),
    .dout  (srl_out)
  );

  always_comb begin
    shifted   = a_q.left ? bit_rev(srl_out) : srl_out;
    sign_mask = '0;
    if (a_q.neg) begin
      if (a_q.word) sign_mask = {32'b0, ~(32'hFFFF_FFFF >> a_q.shamt[4:0])};
      else          sign_mask = ~({XLEN{1'b1}} >> a_q.shamt);
    end
    fin = shifted | sign_mask;
    if (a_q.word) fin = {{(XLEN-32){fin[31]}}, fin[31:0]};
    if (a_q.err)  fin = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_valid <= 1'b0;
      result  <= '0;
      out_err <= 1'b0;
    end else begin
      if (flush)      b_valid <= 1'b0;
      else if (b_adv) b_valid <= a_valid;
      if (b_adv && a_valid) begin
        result  <= fin;
        out_err <= a_q.err;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed vector table, stall/flush/reset
// sequences and a randomized stream scored against an arithmetic model.
module tb_shift_pipe;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [2:0]  op;
  logic [63:0] rs1, rs2, result;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q[$];
  logic        held;
  logic [63:0] held_res;
  logic        last_acc;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  shift_pipe #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_err   (out_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [64:0] model(input logic [2:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] r;
    logic [31:0] t;
    logic [31:0] w;
    w = a[31:0];
    case (o)
      3'b000: return {1'b0, a << b[5:0]};
      3'b001: return {1'b0, a >> b[5:0]};
      3'b010: begin r = $signed(a) >>> b[5:0]; return {1'b0, r}; end
      3'b100: begin t = w << b[4:0]; return {1'b0, {32{t[31]}}, t}; end
      3'b101: begin t = w >> b[4:0]; return {1'b0, {32{t[31]}}, t}; end
      3'b110: begin t = $signed(w) >>> b[4:0]; return {1'b0, {32{t[31]}}, t}; end
      default: return {1'b1, 64'd0};
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: score the handshakes seen just after the inputs settle, then
  // advance to the next falling edge.
  task automatic step();
    logic [64:0] e;
    #1;
    if (held) begin
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", result, held_res);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", result, e[63:0]);
        chk("sb_err", 64'(out_err), 64'(e[64]));
      end
    end
    last_acc = in_valid && in_ready && !flush;
    if (flush) exp_q.delete();
    if (last_acc) exp_q.push_back(model(op, rs1, rs2));
    held     = out_valid && !out_ready && !flush;
    held_res = result;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    op = o; rs1 = a; rs2 = b;
  endtask

  task automatic send(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    drive(o, a, b);
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 64'h8000_0000_0000_0000, 64'd4,  64'hF800_0000_0000_0000, 1'b0};
    vecs[1]  = '{3'b100, 64'h0000_0000_4000_0001, 64'h21, 64'hFFFF_FFFF_8000_0002, 1'b0};
    vecs[2]  = '{3'b101, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'h0000_0000_0000_0001, 1'b0};
    vecs[3]  = '{3'b110, 64'hFFFF_FFFF_8000_0000, 64'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{3'b011, 64'h0000_0000_0000_1234, 64'd0,  64'h0,                   1'b1};
    vecs[5]  = '{3'b000, 64'h0000_0000_0000_0001, 64'd63, 64'h8000_0000_0000_0000, 1'b0};
    vecs[6]  = '{3'b001, 64'h8000_0000_0000_0000, 64'h40, 64'h8000_0000_0000_0000, 1'b0};
    vecs[7]  = '{3'b100, 64'h1234_5678_8765_4321, 64'd0,  64'hFFFF_FFFF_8765_4321, 1'b0};
    vecs[8]  = '{3'b010, 64'h7000_0000_0000_0000, 64'd4,  64'h0700_0000_0000_0000, 1'b0};
    vecs[9]  = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,  64'h0,                   1'b1};
    vecs[10] = '{3'b110, 64'h0000_0000_7FFF_FFFF, 64'h3F, 64'h0,                   1'b0};
    vecs[11] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 64'h1,                   1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'b000; rs1 = '0; rs2 = '0;
    held = 1'b0; held_res = '0; last_acc = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_out_err", 64'(out_err), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // directed table, one request at a time with latency checks
    for (int i = 0; i < 12; i++) begin
      out_ready = 1'b1;
      drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2);
      step();
      chk("vec_accept", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
      chk("vec_lat1_valid", 64'(out_valid), 64'd0);
      step();
      chk("vec_lat2_valid", 64'(out_valid), 64'd1);
      chk("vec_result", result, vecs[i].res);
      chk("vec_err", 64'(out_err), 64'(vecs[i].err));
      step();
    end
    drain();

    // back-to-back with a stalled consumer
    out_ready = 1'b0;
    drive(3'b000, 64'h0000_0000_0000_000F, 64'd4);
    step();
    drive(3'b001, 64'hF000_0000_0000_0000, 64'd8);
    step();
    drive(3'b010, 64'h8000_0000_0000_00FF, 64'd12);
    #1 chk("b2b_in_ready_low", 64'(in_ready), 64'd0);
    step();
    step();
    out_ready = 1'b1;
    send(3'b010, 64'h8000_0000_0000_00FF, 64'd12);
    send(3'b101, 64'hFFFF_FFFF_F000_0000, 64'd28);
    drain();

    // flush with both stages occupied
    out_ready = 1'b0;
    send(3'b000, 64'h1, 64'd1);
    send(3'b000, 64'h2, 64'd2);
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    drive(3'b001, 64'hDEAD, 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) step();
    chk("flush_nothing_left", 64'(out_valid), 64'd0);

    // randomized stream
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 39) == 0);
      op  = 3'($urandom_range(0, 7));
      rs1 = {$urandom(), $urandom()};
      rs2 = {$urandom(), $urandom()};
      step();
    end
    flush = 1'b0;
    drain();

    // asynchronous reset mid-stream
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, 64'($urandom_range(0, 63)));
      step();
    end
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_result", result, 64'd0);
    chk("async_rst_out_err", 64'(out_err), 64'd0);
    exp_q.delete();
    held = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    chk("post_reset_no_stale", 64'(out_valid), 64'd0);
    send(3'b110, 64'h0000_0000_8000_0000, 64'd4);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
